// File: rtl/adbg_lint_arb_pkg.sv
// -----------------------------------------------------------------------------
// adbg_lint_arb_pkg
// Shared types and helpers for the debug lint arbiter.
//   state_e      : arbiter FSM states
//   LINT_OPC_*   : lint response opcode values (OK / error)
//   wrap_add     : (a + b) mod n, used for rotating-priority index math
// -----------------------------------------------------------------------------
package adbg_lint_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic LINT_OPC_OK  = 1'b0;
  localparam logic LINT_OPC_ERR = 1'b1;

  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/adbg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adbg_rr_arbiter
// Combinational rotating-priority picker. Searches req upward from ptr with
// wrap-around and returns the first asserted index.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index with highest priority
//   gnt   out NUM_REQ  one-hot pick (all zero when no request)
//   idx   out IDX_W    index of the pick
//   valid out 1        at least one request asserted
// -----------------------------------------------------------------------------
module adbg_rr_arbiter
  import adbg_lint_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk from the lowest priority offset to the highest; the last hit
  // overwrites earlier ones, so the nearest index at or above ptr wins.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand     = wrap_add(int'(ptr), k, NUM_REQ);
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/adbg_lint_arbiter.sv
// -----------------------------------------------------------------------------
// adbg_lint_arbiter
// Shares one lint master port between NUM_REQ lint requesters. Round-robin
// arbitration, one transaction in flight, response routed back to the owner.
// Optional feature macro: ADBG_LINT_ARB_TIMEOUT_EN (response timeout counter
// plus timeout_o pulse; without it S_RESP waits indefinitely).
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   s_req_i/add/wen/wdata/be/aux  per-requester lint request (flattened)
//   s_gnt_o, s_r_valid_o          per-requester grant / response valid
//   s_r_rdata_o/opc_o/aux_o       shared response payload
//   m_req_o ... m_aux_o           master lint request
//   m_gnt_i, m_r_*_i              master grant / response
//   busy_o, owner_o               transaction in progress / current owner
//   timeout_o                     response timeout pulse (macro only)
// -----------------------------------------------------------------------------
module adbg_lint_arbiter
  import adbg_lint_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int AUX_WIDTH      = 6,
  parameter bit WRITE_RSP      = 1'b0,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W         = $clog2(NUM_REQ),
  localparam int BE_W          = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_REQ-1:0]              s_req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_add_i,
  input  logic [NUM_REQ-1:0]              s_wen_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]         s_be_i,
  input  logic [NUM_REQ*AUX_WIDTH-1:0]    s_aux_i,
  output logic [NUM_REQ-1:0]              s_gnt_o,
  output logic [NUM_REQ-1:0]              s_r_valid_o,
  output logic [DATA_WIDTH-1:0]           s_r_rdata_o,
  output logic                            s_r_opc_o,
  output logic                            s_r_aux_o,
  output logic                            m_req_o,
  output logic [ADDR_WIDTH-1:0]           m_add_o,
  output logic                            m_wen_o,
  output logic [DATA_WIDTH-1:0]           m_wdata_o,
  output logic [BE_W-1:0]                 m_be_o,
  output logic [AUX_WIDTH-1:0]            m_aux_o,
  input  logic                            m_gnt_i,
  input  logic                            m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]           m_r_rdata_i,
  input  logic                            m_r_opc_i,
  input  logic                            m_r_aux_i,
`ifdef ADBG_LINT_ARB_TIMEOUT_EN
  output logic                            timeout_o,
`endif
  output logic                            busy_o,
  output logic [IDX_W-1:0]                owner_o
);

  state_e           state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] owner_inc;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               timeout_hit;

  // Per-requester views of the flattened request buses.
  logic [ADDR_WIDTH-1:0] add_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [BE_W-1:0]       be_arr    [NUM_REQ];
  logic [AUX_WIDTH-1:0]  aux_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign add_arr[gi]   = s_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = s_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[gi]    = s_be_i[gi*BE_W +: BE_W];
    assign aux_arr[gi]   = s_aux_i[gi*AUX_WIDTH +: AUX_WIDTH];
  end

  logic own_req, own_wen;
  assign own_req   = s_req_i[owner_reg];
  assign own_wen   = s_wen_i[owner_reg];
  assign owner_inc = IDX_W'(wrap_add(int'(owner_reg), 1, NUM_REQ));

  adbg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (s_req_i),
    .ptr   (rr_ptr_reg),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // The one-hot pick is not needed here: the index alone is registered.
  logic unused_arb_gnt;
  assign unused_arb_gnt = ^arb_gnt;

`ifdef ADBG_LINT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt_reg;

  // Held at zero outside S_RESP, so it is zero on the first S_RESP cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 to_cnt_reg <= '0;
    else if (state_reg != S_RESP) to_cnt_reg <= '0;
    else                         to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == S_RESP) && !m_r_valid_i &&
                       (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg  <= S_IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      S_IDLE: begin
        if (arb_valid) begin
          owner_next = arb_idx;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // A withdrawn request forfeits the slot without moving the pointer.
        if (!own_req) begin
          state_next = S_IDLE;
        end else if (m_gnt_i) begin
          if (own_wen || WRITE_RSP) begin
            state_next = S_RESP;
          end else begin
            state_next  = S_IDLE;
            rr_ptr_next = owner_inc;
          end
        end
      end
      S_RESP: begin
        if (m_r_valid_i || timeout_hit) begin
          state_next  = S_IDLE;
          rr_ptr_next = owner_inc;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    m_req_o     = 1'b0;
    m_add_o     = '0;
    m_wen_o     = 1'b1;
    m_wdata_o   = '0;
    m_be_o      = '0;
    m_aux_o     = '0;
    s_gnt_o     = '0;
    s_r_valid_o = '0;
    s_r_rdata_o = m_r_rdata_i;
    s_r_opc_o   = m_r_opc_i;
    s_r_aux_o   = m_r_aux_i;
    if (timeout_hit) begin
      s_r_rdata_o = '0;
      s_r_opc_o   = LINT_OPC_ERR;
    end
    case (state_reg)
      S_REQ: begin
        m_req_o   = own_req;
        m_add_o   = add_arr[owner_reg];
        m_wen_o   = own_wen;
        m_wdata_o = wdata_arr[owner_reg];
        m_be_o    = be_arr[owner_reg];
        m_aux_o   = aux_arr[owner_reg];
        if (own_req && m_gnt_i) s_gnt_o[owner_reg] = 1'b1;
      end
      S_RESP: begin
        if (m_r_valid_i || timeout_hit) s_r_valid_o[owner_reg] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_reg != S_IDLE);
  assign owner_o = owner_reg;

endmodule

// File: tb/tb_adbg_lint_arbiter.sv
module tb_adbg_lint_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int XW = 6;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    s_req, s_wen, s_gnt, s_r_valid;
  logic [N*AW-1:0] s_add;
  logic [N*DW-1:0] s_wdata;
  logic [N*BW-1:0] s_be;
  logic [N*XW-1:0] s_aux;
  logic [DW-1:0]   s_r_rdata, m_wdata, m_r_rdata;
  logic            s_r_opc, s_r_aux, m_req, m_wen, m_gnt, m_r_valid, m_r_opc, m_r_aux;
  logic [AW-1:0]   m_add;
  logic [BW-1:0]   m_be;
  logic [XW-1:0]   m_aux;
  logic            busy;
  logic [0:0]      owner;
`ifdef ADBG_LINT_ARB_TIMEOUT_EN
  logic            timeout;
`endif

  always #5 clk = ~clk;

  adbg_lint_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUX_WIDTH(XW),
`ifdef ADBG_LINT_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .WRITE_RSP(1'b0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata),
    .s_be_i(s_be), .s_aux_i(s_aux),
    .s_gnt_o(s_gnt), .s_r_valid_o(s_r_valid), .s_r_rdata_o(s_r_rdata),
    .s_r_opc_o(s_r_opc), .s_r_aux_o(s_r_aux),
    .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_wdata_o(m_wdata),
    .m_be_o(m_be), .m_aux_o(m_aux),
    .m_gnt_i(m_gnt), .m_r_valid_i(m_r_valid), .m_r_rdata_i(m_r_rdata),
    .m_r_opc_i(m_r_opc), .m_r_aux_i(m_r_aux),
`ifdef ADBG_LINT_ARB_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .busy_o(busy), .owner_o(owner)
  );

  typedef struct {
    int          kind;   // 0 = grant, 1 = response valid
    int          port;
    logic [63:0] data;
    logic        opc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input int kind, input int port, input logic [63:0] data, input logic opc);
    exp_t e;
    e.kind = kind; e.port = port; e.data = data; e.opc = opc;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input int p);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d port %0d expected none at %0t", kind, p, $time);
    end else begin
      e = exp_q.pop_front();
      $display("evt %s port %0d rdata 0x%0h opc %0b at %0t",
               (kind == 0) ? "gnt" : "rvalid", p, s_r_rdata, s_r_opc, $time);
      check("evt_kind", 64'(kind), 64'(e.kind));
      check("evt_port", 64'(p), 64'(e.port));
      if (kind == 1) begin
        check("r_rdata", s_r_rdata, e.data);
        check("r_opc", 64'(s_r_opc), 64'(e.opc));
      end
    end
  endtask

  // Monitor: every grant / response the DUT presents is matched in order.
  always @(negedge clk) begin
    if (rstn) begin
      for (int p = 0; p < N; p++) begin
        if (s_gnt[p])     mon_event(0, p);
        if (s_r_valid[p]) mon_event(1, p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] add, input logic wen, input logic [63:0] wd);
    s_add[p*AW +: AW]   = add;
    s_wen[p]            = wen;
    s_wdata[p*DW +: DW] = wd;
    s_be[p*BW +: BW]    = '1;
    s_aux[p*XW +: XW]   = XW'(p + 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  int nw;

  initial begin
    rstn = 1'b0; s_req = '0; s_wen = '1; s_add = '0; s_wdata = '0; s_be = '0; s_aux = '0;
    m_gnt = 1'b0; m_r_valid = 1'b0; m_r_rdata = '0; m_r_opc = 1'b0; m_r_aux = 1'b0;
    tick();
    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_wen", 64'(m_wen), 64'd1);
    check("rst_gnt", 64'(s_gnt), 64'd0);
    check("rst_rvalid", 64'(s_r_valid), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    do_reset();

    // 1: port0 read, slave grants one cycle late, response two cycles later
    set_port(0, 32'h1000, 1'b1, 64'h0);
    s_req = 2'b01;
    tick();
    check("t1_m_req", 64'(m_req), 64'd1);
    check("t1_m_add", 64'(m_add), 64'h1000);
    check("t1_m_wen", 64'(m_wen), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_owner", 64'(owner), 64'd0);
    tick();
    expect_evt(0, 0, 64'h0, 1'b0);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; s_req = 2'b00;
    check("t1_resp_m_req", 64'(m_req), 64'd0);
    check("t1_resp_busy", 64'(busy), 64'd1);
    tick();
    expect_evt(1, 0, 64'hA5A5_0000_1111_2222, 1'b0);
    m_r_valid = 1'b1; m_r_rdata = 64'hA5A5_0000_1111_2222;
    tick();
    m_r_valid = 1'b0; m_r_rdata = '0;
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: both ports write continuously, grants alternate starting at port0
    do_reset();
    set_port(0, 32'h2000, 1'b0, 64'h1111);
    set_port(1, 32'h3000, 1'b0, 64'h2222);
    s_req = 2'b11;
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      m_gnt = m_req;
      if (m_req) begin
        check("t2_m_add", 64'(m_add), (nw % 2 == 0) ? 64'h2000 : 64'h3000);
        check("t2_m_wdata", m_wdata, (nw % 2 == 0) ? 64'h1111 : 64'h2222);
        check("t2_m_wen", 64'(m_wen), 64'd0);
        expect_evt(0, nw % 2, 64'h0, 1'b0);
        nw++;
      end
      if (i == 7) s_req = 2'b00;
    end
    check("t2_write_count", 64'(nw), 64'd4);
    m_gnt = 1'b0;
    tick();
    check("t2_idle", 64'(busy), 64'd0);

    // 3: port1 read outstanding blocks port0 until its response
    set_port(1, 32'h4000, 1'b1, 64'h0);
    s_req = 2'b10;
    tick();
    check("t3_owner1", 64'(owner), 64'd1);
    m_gnt = 1'b1;
    expect_evt(0, 1, 64'h0, 1'b0);
    tick();
    m_gnt = 1'b0;
    set_port(0, 32'h5000, 1'b0, 64'h5555);
    s_req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_m_req", 64'(m_req), 64'd0);
      check("t3_hold_owner", 64'(owner), 64'd1);
    end
    expect_evt(1, 1, 64'h0123_4567_89AB_CDEF, 1'b1);
    m_r_valid = 1'b1; m_r_rdata = 64'h0123_4567_89AB_CDEF; m_r_opc = 1'b1;
    tick();
    m_r_valid = 1'b0; m_r_rdata = '0; m_r_opc = 1'b0;
    tick();
    check("t3_owner0", 64'(owner), 64'd0);
    check("t3_m_add0", 64'(m_add), 64'h5000);
    m_gnt = 1'b1;
    expect_evt(0, 0, 64'h0, 1'b0);
    tick();
    m_gnt = 1'b0; s_req = 2'b00;
    check("t3_idle", 64'(busy), 64'd0);

    // 4: port0 withdraws before grant; pointer must stay at port0
    do_reset();
    set_port(0, 32'h6000, 1'b1, 64'h0);
    set_port(1, 32'h7000, 1'b1, 64'h0);
    s_req = 2'b01;
    tick();
    check("t4_m_req", 64'(m_req), 64'd1);
    s_req = 2'b00;
    tick();
    check("t4_busy_drop", 64'(busy), 64'd0);
    check("t4_m_req_drop", 64'(m_req), 64'd0);
    s_req = 2'b11;
    tick();
    check("t4_ptr_kept", 64'(owner), 64'd0);
    s_req = 2'b00;
    tick();
    check("t4_idle", 64'(busy), 64'd0);

    // 5: reset during S_RESP, late response is dropped
    s_req = 2'b01;
    tick();
    m_gnt = 1'b1;
    expect_evt(0, 0, 64'h0, 1'b0);
    tick();
    m_gnt = 1'b0; s_req = 2'b00;
    check("t5_busy_resp", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_m_req", 64'(m_req), 64'd0);
    check("t5_rst_m_wen", 64'(m_wen), 64'd1);
    check("t5_rst_owner", 64'(owner), 64'd0);
    tick();
    rstn = 1'b1;
    m_r_valid = 1'b1; m_r_rdata = 64'hDEAD_BEEF;
    #1;
    check("t5_no_rvalid", 64'(s_r_valid), 64'd0);
    tick();
    m_r_valid = 1'b0; m_r_rdata = '0;
    check("t5_idle", 64'(busy), 64'd0);

`ifdef ADBG_LINT_ARB_TIMEOUT_EN
    // 6: response timeout after 16 cycles in S_RESP
    s_req = 2'b01;
    tick();
    m_gnt = 1'b1;
    expect_evt(0, 0, 64'h0, 1'b0);
    tick();
    m_gnt = 1'b0; s_req = 2'b00; m_r_rdata = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) expect_evt(1, 0, 64'h0, 1'b1);
      check("t6_timeout", 64'(timeout), (i == 15) ? 64'd1 : 64'd0);
      tick();
    end
    m_r_rdata = '0;
    check("t6_idle", 64'(busy), 64'd0);
`endif

    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
